alu_pipe_param: RTL
===================

// Module: alu_pipe_param
// PURPOSE
//  Parametrised, handshaked successor to the team's 8-bit clocked ALU. Accepts one
//  operation at a time over a valid/ready input channel and returns a registered
//  result with flags over a valid/ready output channel. Adds XOR, shifts and an
//  iterative multi-cycle unsigned multiply, plus a sticky overflow flag.
//  Sits between the operand sequencer and the result writeback stage.
// PARAMETERS
//  WIDTH    8                    operand/result width, >= 4, power of two
//  SHW      $clog2(WIDTH)        shift-amount bits taken from B (derived, do not override)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand/op presented
//  in_ready   out  1      block can accept an operation this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (also the shift amount)
//  op         in   3      0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHL,6 SHR,7 MUL
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result this cycle
//  result     out  WIDTH  result
//  carry      out  1      carry/borrow/shift-out/mul-high flag
//  zero       out  1      result == 0
//  overflow   out  1      signed overflow (ADD/SUB), mul truncation (MUL), else 0
//  negative   out  1      result[WIDTH-1]
//  sticky_ovf out  1      set by any delivered result with overflow=1
//  clr_sticky in   1      clears sticky_ovf
// BEHAVIOUR
//  - Reset: FSM=IDLE, out_valid=0, result/carry/zero/overflow/negative=0,
//    sticky_ovf=0, mul counter=0. Reset mid-MUL aborts it; no result is produced.
//  - FSM: IDLE, MUL, HOLD.
//    IDLE: in_ready=1. On in_valid, op!=MUL: compute, register outputs, out_valid=1
//          -> HOLD. On in_valid, op==MUL: latch a,b, clear accumulator -> MUL.
//    MUL:  in_ready=0; one shift-add step per cycle, WIDTH steps; after the last
//          step, register outputs, out_valid=1 -> HOLD.
//    HOLD: out_valid=1, outputs stable. If out_ready: out_valid=0 and in_ready=1 in
//          the same cycle (accepting a new op here behaves as IDLE); else stay.
//  - in_ready = (state==IDLE) | (state==HOLD & out_ready); it is combinational.
//  - Latency (accept edge to out_valid high): 1 edge for ops 0-6, WIDTH+1 edges for MUL.
//  - Arithmetic, internal WIDTH+1 bits:
//    ADD: carry=sum[WIDTH]; ovf=(a[msb]==b[msb])&(res[msb]!=a[msb]).
//    SUB: res=a-b; carry=borrow (a<b unsigned); ovf=(a[msb]!=b[msb])&(res[msb]!=a[msb]).
//    AND/OR/XOR: carry=0, ovf=0.
//    SHL/SHR: logical, zero-fill; amount n=b unsigned. n=0: res=a, carry=0.
//      1<=n<WIDTH: carry=last bit shifted out (a[WIDTH-n] / a[n-1]). n>=WIDTH: res=0,
//      carry=0. ovf=0.
//    MUL: unsigned 2*WIDTH product; res=low WIDTH bits; carry=ovf=|high WIDTH bits.
//  - zero and negative derive from registered result, all op codes.
//  - sticky_ovf: updated on the edge where out_valid rises. A new overflow in the
//    same cycle as clr_sticky sets it (set wins); clr_sticky otherwise clears.
//  - Inputs a,b,op are sampled only on the accept edge; changes later have no effect.
// TESTING (WIDTH=8)
//  1 ADD a=7F b=01 -> next edge out_valid=1, result=80, ovf=1, neg=1, carry=0, zero=0; sticky_ovf=1.
//  2 SUB a=00 b=01 -> result=FF, carry=1, ovf=0; SHL a=81 b=01 -> result=02, carry=1; SHR b=08 -> result=00, zero=1.
//  3 MUL a=10 b=10 -> out_valid exactly 9 edges after accept, result=00, carry=1, ovf=1, zero=1; in_ready=0 throughout.
//  4 Backpressure: out_ready=0 for 3 cycles after ADD 03+04 -> result=07 held, in_ready=0; out_ready=1 with new in_valid -> accepted same cycle.
//  5 rst high 4 cycles into MUL 0F*0F -> all outputs 0, IDLE next cycle; following MUL 0F*0F -> result=E1, carry=0.
//  6 clr_sticky asserted on the edge delivering ADD 80+80 (ovf=1) -> sticky_ovf stays 1; next clr_sticky alone -> 0.

Source files
------------

// File: rtl/alu_pipe_param.sv
// alu_pipe_param: parametrised ALU with valid/ready channels on both sides.
// Single-cycle ops (ADD..SHR) and an iterative shift-add unsigned multiply.
// Results and flags are registered and held until the consumer takes them.
// A sticky overflow flag collects the overflow flag of every delivered result.
module alu_pipe_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             negative,
  output logic             sticky_ovf,
  input  logic             clr_sticky
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Registered state and outputs
  state_t             state_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q;
  logic               zero_q;
  logic               overflow_q;
  logic               negative_q;
  logic               sticky_q;

  // Multiplier datapath: shifting multiplicand, shifting multiplier, accumulator
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;

  // Combinational helpers
  logic               accept_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH:0]     shl_s;
  logic [WIDTH:0]     shr_s;
  logic               big_shift_s;
  logic [WIDTH-1:0]   alu_res_d;
  logic               alu_carry_d;
  logic               alu_ovf_d;
  logic [2*WIDTH-1:0] acc_d;
  logic               mul_hi_s;

  assign in_ready = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
  assign accept_s = in_valid & in_ready;

  // One extra bit on top of the operands carries out the carry/borrow/shift-out bit.
  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};
  assign shl_s  = {1'b0, a} << b[SHW-1:0];
  assign shr_s  = {a, 1'b0} >> b[SHW-1:0];
  // WIDTH is a power of two, so any set bit at or above SHW means b >= WIDTH.
  assign big_shift_s = |b[WIDTH-1:SHW];

  // Next accumulator value: add the multiplicand when the current multiplier bit is set.
  assign acc_d    = acc_q + ({(2*WIDTH){mplier_q[0]}} & mcand_q);
  assign mul_hi_s = |acc_d[2*WIDTH-1:WIDTH];

  // Single-cycle operation result and flags for the op on the input channel.
  always_comb begin
    alu_res_d   = '0;
    alu_carry_d = 1'b0;
    alu_ovf_d   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res_d   = sum_s[WIDTH-1:0];
        alu_carry_d = sum_s[WIDTH];
        alu_ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) & (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_d   = diff_s[WIDTH-1:0];
        alu_carry_d = diff_s[WIDTH];
        alu_ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) & (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res_d = a & b;
      OP_OR:  alu_res_d = a | b;
      OP_XOR: alu_res_d = a ^ b;
      OP_SHL: begin
        if (big_shift_s) begin
          alu_res_d   = '0;
          alu_carry_d = 1'b0;
        end else begin
          alu_res_d   = shl_s[WIDTH-1:0];
          alu_carry_d = shl_s[WIDTH];
        end
      end
      OP_SHR: begin
        if (big_shift_s) begin
          alu_res_d   = '0;
          alu_carry_d = 1'b0;
        end else begin
          alu_res_d   = shr_s[WIDTH:1];
          alu_carry_d = shr_s[0];
        end
      end
      default: begin
        alu_res_d   = '0;
        alu_carry_d = 1'b0;
        alu_ovf_d   = 1'b0;
      end
    endcase
  end

  // Control FSM, multiply iteration and registered result/flags/sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      negative_q  <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
    end else begin
      // Clear first; a delivery with overflow below overrides it (set wins).
      if (clr_sticky) begin
        sticky_q <= 1'b0;
      end
      case (state_q)
        S_IDLE, S_HOLD: begin
          if (accept_s) begin
            if (op == OP_MUL) begin
              mcand_q     <= {{WIDTH{1'b0}}, a};
              mplier_q    <= b;
              acc_q       <= '0;
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              state_q     <= S_MUL;
            end else begin
              result_q    <= alu_res_d;
              carry_q     <= alu_carry_d;
              overflow_q  <= alu_ovf_d;
              zero_q      <= (alu_res_d == '0);
              negative_q  <= alu_res_d[WIDTH-1];
              out_valid_q <= 1'b1;
              state_q     <= S_HOLD;
              if (alu_ovf_d) begin
                sticky_q <= 1'b1;
              end
            end
          end else if ((state_q == S_HOLD) && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + {{(SHW-1){1'b0}}, 1'b1};
          // Last of WIDTH steps: deliver the completed product in the same edge.
          if (&cnt_q) begin
            result_q    <= acc_d[WIDTH-1:0];
            carry_q     <= mul_hi_s;
            overflow_q  <= mul_hi_s;
            zero_q      <= (acc_d[WIDTH-1:0] == '0);
            negative_q  <= acc_d[WIDTH-1];
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_HOLD;
            if (mul_hi_s) begin
              sticky_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign carry      = carry_q;
  assign zero       = zero_q;
  assign overflow   = overflow_q;
  assign negative   = negative_q;
  assign sticky_ovf = sticky_q;

endmodule
